// File: rtl/wash_cycle_scheduler.sv
// wash_cycle_scheduler
//   Single-timer sequencer for the wash program: IDLE -> FILL -> WASH -> RINSE
//   [-> WASH -> RINSE when double_wash] -> SPIN -> DONE -> IDLE.
//   One shared prescaler produces a once-per-second tick and one seconds
//   down-counter times whichever phase is active.
//
// Optional feature: define ABORT_EN to add the abort input. An abort in FILL,
// WASH or RINSE jumps straight to SPIN.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high, highest priority
//   coin_in      in   start request, honoured only in IDLE
//   double_wash  in   two wash/rinse rounds; latched with the coin
//   timer_pause  in   freezes timing, honoured only in SPIN
//   clk_freq     in   clock rate code (TPS = TICK_DIV_BASE << code); latched with the coin
//   abort        in   (ABORT_EN only) skip to SPIN from FILL/WASH/RINSE
//   phase        out  IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5 (state debug view)
//   fill_en/wash_en/rinse_en/spin_en  out  per-phase actuator enables
//   round2       out  high during the second WASH and second RINSE
//   sec_left     out  seconds remaining in the current phase
//   busy         out  phase is not IDLE
//   wash_done    out  one-cycle pulse in DONE
module wash_cycle_scheduler #(
    parameter int TICK_DIV_BASE = 1000000,
    parameter int FILL_SEC      = 120,
    parameter int WASH_SEC      = 300,
    parameter int RINSE_SEC     = 120,
    parameter int SPIN_SEC      = 60,
    parameter int SEC_W         = 9,
    parameter int PRE_W         = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_in,
    input  logic             double_wash,
    input  logic             timer_pause,
    input  logic [1:0]       clk_freq,
`ifdef ABORT_EN
    input  logic             abort,
`endif
    output logic [2:0]       phase,
    output logic             fill_en,
    output logic             wash_en,
    output logic             rinse_en,
    output logic             spin_en,
    output logic             round2,
    output logic [SEC_W-1:0] sec_left,
    output logic             busy,
    output logic             wash_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5
    } phase_e;

    localparam logic [SEC_W-1:0] FILL_L  = SEC_W'(FILL_SEC);
    localparam logic [SEC_W-1:0] WASH_L  = SEC_W'(WASH_SEC);
    localparam logic [SEC_W-1:0] RINSE_L = SEC_W'(RINSE_SEC);
    localparam logic [SEC_W-1:0] SPIN_L  = SEC_W'(SPIN_SEC);

    phase_e             phase_q, phase_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               dbl_q, dbl_d;
    logic [1:0]         freq_q, freq_d;
    logic               round2_q, round2_d;

    logic [PRE_W-1:0]   tps_m1;
    logic               tick;
    logic               counting;
    logic               abort_req;

`ifdef ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        phase_d  = phase_q;
        sec_d    = sec_q;
        pre_d    = pre_q;
        dbl_d    = dbl_q;
        freq_d   = freq_q;
        round2_d = round2_q;
        counting = 1'b0;

        // Prescaler terminal count follows the rate code latched at start.
        tps_m1 = (PRE_W'(TICK_DIV_BASE) << freq_q) - PRE_W'(1);
        tick   = (pre_q == tps_m1);

        case (phase_q)
            S_IDLE: begin
                if (coin_in) begin
                    dbl_d    = double_wash;
                    freq_d   = clk_freq;
                    phase_d  = S_FILL;
                    sec_d    = FILL_L;
                    pre_d    = '0;
                    round2_d = 1'b0;
                end
            end
            S_FILL, S_WASH, S_RINSE: begin
                if (abort_req) begin
                    phase_d  = S_SPIN;
                    sec_d    = SPIN_L;
                    pre_d    = '0;
                    round2_d = 1'b0;
                end else begin
                    counting = 1'b1;
                end
            end
            // Pause freezes both prescaler and seconds, including the final tick.
            S_SPIN: counting = !timer_pause;
            S_DONE: begin
                phase_d = S_IDLE;
                sec_d   = '0;
                pre_d   = '0;
            end
            default: begin
                phase_d = S_IDLE;
                sec_d   = '0;
                pre_d   = '0;
            end
        endcase

        if (counting) begin
            if (!tick) begin
                pre_d = pre_q + PRE_W'(1);
            end else begin
                pre_d = '0;
                if (sec_q != SEC_W'(1)) begin
                    sec_d = sec_q - SEC_W'(1);
                end else begin
                    // Last second of the phase expired: load the successor.
                    case (phase_q)
                        S_FILL: begin
                            phase_d = S_WASH;
                            sec_d   = WASH_L;
                        end
                        S_WASH: begin
                            phase_d = S_RINSE;
                            sec_d   = RINSE_L;
                        end
                        S_RINSE: begin
                            if (dbl_q && !round2_q) begin
                                phase_d  = S_WASH;
                                sec_d    = WASH_L;
                                round2_d = 1'b1;
                            end else begin
                                phase_d  = S_SPIN;
                                sec_d    = SPIN_L;
                                round2_d = 1'b0;
                            end
                        end
                        default: begin
                            phase_d = S_DONE;
                            sec_d   = '0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= S_IDLE;
            sec_q    <= '0;
            pre_q    <= '0;
            dbl_q    <= 1'b0;
            freq_q   <= 2'd0;
            round2_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            sec_q    <= sec_d;
            pre_q    <= pre_d;
            dbl_q    <= dbl_d;
            freq_q   <= freq_d;
            round2_q <= round2_d;
        end
    end

    assign phase     = phase_q;
    assign fill_en   = (phase_q == S_FILL);
    assign wash_en   = (phase_q == S_WASH);
    assign rinse_en  = (phase_q == S_RINSE);
    assign spin_en   = (phase_q == S_SPIN) && !timer_pause;
    assign round2    = round2_q;
    assign sec_left  = sec_q;
    assign busy      = (phase_q != S_IDLE);
    assign wash_done = (phase_q == S_DONE);

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// Bench for wash_cycle_scheduler, built with the short durations of the test
// plan. The reference model tracks each phase as a remaining-cycle count
// (DUR * TPS) and derives seconds-left by ceiling division.
module tb_wash_cycle_scheduler;

    localparam int TB_BASE  = 2;
    localparam int TB_FILL  = 2;
    localparam int TB_WASH  = 3;
    localparam int TB_RINSE = 2;
    localparam int TB_SPIN  = 2;
    localparam int SEC_W    = 9;
    localparam int PRE_W    = 24;
    localparam int OW       = 10 + SEC_W;
`ifdef ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             coin_in;
    logic             double_wash;
    logic             timer_pause;
    logic [1:0]       clk_freq;
    logic             abort;
    logic [2:0]       phase;
    logic             fill_en, wash_en, rinse_en, spin_en, round2, busy, wash_done;
    logic [SEC_W-1:0] sec_left;

    int n_vec;
    int n_err;

    // reference model state
    int m_phase;
    int m_rem;
    int m_tps;
    bit m_dbl;
    bit m_round;

    logic [SEC_W-1:0] exp_q[$];

    wash_cycle_scheduler #(
        .TICK_DIV_BASE(TB_BASE), .FILL_SEC(TB_FILL), .WASH_SEC(TB_WASH),
        .RINSE_SEC(TB_RINSE), .SPIN_SEC(TB_SPIN), .SEC_W(SEC_W), .PRE_W(PRE_W)
    ) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .double_wash(double_wash),
        .timer_pause(timer_pause), .clk_freq(clk_freq),
`ifdef ABORT_EN
        .abort(abort),
`endif
        .phase(phase), .fill_en(fill_en), .wash_en(wash_en), .rinse_en(rinse_en),
        .spin_en(spin_en), .round2(round2), .sec_left(sec_left), .busy(busy),
        .wash_done(wash_done)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [OW-1:0] dut_obs();
        return {phase, fill_en, wash_en, rinse_en, spin_en, round2, sec_left, busy, wash_done};
    endfunction

    function automatic logic [OW-1:0] model_obs();
        logic [2:0]       p;
        int               s;
        logic [SEC_W-1:0] sv;
        p  = m_phase[2:0];
        s  = (m_phase >= 1 && m_phase <= 4) ? (m_rem + m_tps - 1) / m_tps : 0;
        sv = s[SEC_W-1:0];
        return {p, m_phase == 1, m_phase == 2, m_phase == 3,
                (m_phase == 4) && !timer_pause, m_round, sv, m_phase != 0, m_phase == 5};
    endfunction

    task automatic model_finish_phase();
        case (m_phase)
            1: begin m_phase = 2; m_rem = TB_WASH * m_tps; end
            2: begin m_phase = 3; m_rem = TB_RINSE * m_tps; end
            3: begin
                if (m_dbl && !m_round) begin
                    m_phase = 2; m_rem = TB_WASH * m_tps; m_round = 1'b1;
                end else begin
                    m_phase = 4; m_rem = TB_SPIN * m_tps; m_round = 1'b0;
                end
            end
            default: begin m_phase = 5; m_rem = 0; end
        endcase
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_rem = 0; m_round = 1'b0; m_dbl = 1'b0; m_tps = TB_BASE;
        end else begin
            case (m_phase)
                0: if (coin_in) begin
                    m_dbl   = double_wash;
                    m_tps   = TB_BASE << clk_freq;
                    m_phase = 1;
                    m_rem   = TB_FILL * m_tps;
                    m_round = 1'b0;
                end
                1, 2, 3: begin
                    if (ABORT_ON && abort) begin
                        m_phase = 4; m_rem = TB_SPIN * m_tps; m_round = 1'b0;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) model_finish_phase();
                    end
                end
                4: if (!timer_pause) begin
                    m_rem--;
                    if (m_rem == 0) model_finish_phase();
                end
                default: begin m_phase = 0; m_rem = 0; end
            endcase
        end
    endtask

    // driver: set inputs shortly after the falling edge, leave settle time
    task automatic apply(input logic c, input logic d, input logic [1:0] f,
                         input logic p, input logic a, input logic r);
        coin_in = c; double_wash = d; clk_freq = f; timer_pause = p; abort = a; rst = r;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        advance();
    endtask

    function automatic int plan_phase_single(input int cyc);
        if (cyc >= 1 && cyc <= 4)   return 1;
        if (cyc >= 5 && cyc <= 10)  return 2;
        if (cyc >= 11 && cyc <= 14) return 3;
        if (cyc >= 15 && cyc <= 18) return 4;
        if (cyc == 19)              return 5;
        return 0;
    endfunction

    task automatic test_reset();
        logic [OW-1:0] obs;
        do_reset();
        apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        obs = dut_obs();
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs, {OW{1'b0}});
        end
        n_vec++;
        if (obs !== model_obs()) begin
            n_err++;
            $display("FAIL reset_model: got %h expected %h", obs, model_obs());
        end
        advance();
    endtask

    task automatic test_single();
        logic [OW-1:0]    obs, expv;
        logic [SEC_W-1:0] es;
        int               done_at;
        done_at = -1;
        do_reset();
        exp_q = '{9'd2, 9'd2, 9'd1, 9'd1};
        for (int cyc = 0; cyc <= 21; cyc++) begin
            apply(cyc == 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            obs = dut_obs(); expv = model_obs();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL single_model cyc %0d: got %h expected %h", cyc, obs, expv);
            end
            n_vec++;
            if (phase !== 3'(plan_phase_single(cyc))) begin
                n_err++;
                $display("FAIL single_phase cyc %0d: got %0d expected %0d", cyc, phase, plan_phase_single(cyc));
            end
            if (cyc >= 1 && cyc <= 4 && exp_q.size() > 0) begin
                es = exp_q.pop_front();
                n_vec++;
                if (sec_left !== es) begin
                    n_err++;
                    $display("FAIL single_fill_sec cyc %0d: got %0d expected %0d", cyc, sec_left, es);
                end
            end
            if (wash_done === 1'b1) done_at = cyc;
            advance();
        end
        n_vec++;
        if (done_at != 19) begin
            n_err++;
            $display("FAIL single_done_cycle: got %0d expected 19", done_at);
        end
    endtask

    task automatic test_double();
        logic [OW-1:0] obs, expv;
        int            done_at;
        done_at = -1;
        do_reset();
        for (int cyc = 0; cyc <= 31; cyc++) begin
            apply(cyc == 0, cyc == 0, 2'd0, 1'b0, 1'b0, 1'b0);
            obs = dut_obs(); expv = model_obs();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL double_model cyc %0d: got %h expected %h", cyc, obs, expv);
            end
            n_vec++;
            if (round2 !== (cyc >= 15 && cyc <= 24)) begin
                n_err++;
                $display("FAIL double_round2 cyc %0d: got %b expected %b", cyc, round2, (cyc >= 15 && cyc <= 24));
            end
            if (wash_done === 1'b1) done_at = cyc;
            advance();
        end
        n_vec++;
        if (done_at != 29) begin
            n_err++;
            $display("FAIL double_done_cycle: got %0d expected 29", done_at);
        end
    endtask

    task automatic test_freq();
        logic [OW-1:0] obs, expv;
        logic [1:0]    f;
        int            done_at;
        done_at = -1;
        do_reset();
        for (int cyc = 0; cyc <= 39; cyc++) begin
            f = (cyc == 0) ? 2'd1 : (cyc >= 3 ? 2'd3 : 2'd0);
            apply(cyc == 0, cyc >= 3, f, 1'b0, 1'b0, 1'b0);
            obs = dut_obs(); expv = model_obs();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL freq_model cyc %0d: got %h expected %h", cyc, obs, expv);
            end
            n_vec++;
            if (fill_en !== (cyc >= 1 && cyc <= 8)) begin
                n_err++;
                $display("FAIL freq_fill cyc %0d: got %b expected %b", cyc, fill_en, (cyc >= 1 && cyc <= 8));
            end
            if (wash_done === 1'b1) done_at = cyc;
            advance();
        end
        n_vec++;
        if (done_at != 37) begin
            n_err++;
            $display("FAIL freq_done_cycle: got %0d expected 37", done_at);
        end
    endtask

    task automatic test_pause();
        logic [OW-1:0] obs, expv;
        logic          p;
        int            done_at;
        for (int run = 0; run < 2; run++) begin
            done_at = -1;
            do_reset();
            for (int cyc = 0; cyc <= 24; cyc++) begin
                p = (run == 0) ? (cyc >= 16 && cyc <= 18) : (cyc >= 6 && cyc <= 8);
                apply(cyc == 0, 1'b0, 2'd0, p, 1'b0, 1'b0);
                obs = dut_obs(); expv = model_obs();
                n_vec++;
                if (obs !== expv) begin
                    n_err++;
                    $display("FAIL pause_model run %0d cyc %0d: got %h expected %h", run, cyc, obs, expv);
                end
                if (run == 0 && p) begin
                    n_vec++;
                    if (spin_en !== 1'b0) begin
                        n_err++;
                        $display("FAIL pause_spin_en cyc %0d: got %b expected 0", cyc, spin_en);
                    end
                end
                if (wash_done === 1'b1) done_at = cyc;
                advance();
            end
            n_vec++;
            if (done_at != (run == 0 ? 22 : 19)) begin
                n_err++;
                $display("FAIL pause_done_cycle run %0d: got %0d expected %0d", run, done_at, run == 0 ? 22 : 19);
            end
        end
    endtask

    task automatic test_coin_rst();
        logic [OW-1:0] obs, expv;
        int            done_at;
        done_at = -1;
        do_reset();
        for (int cyc = 0; cyc <= 12; cyc++) begin
            apply(cyc == 0 || cyc == 6, 1'b0, 2'd0, 1'b0, 1'b0, cyc == 7);
            obs = dut_obs(); expv = model_obs();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL coin_rst_model cyc %0d: got %h expected %h", cyc, obs, expv);
            end
            if (cyc == 8) begin
                n_vec++;
                if (obs !== '0) begin
                    n_err++;
                    $display("FAIL rst_midrun cyc 8: got %h expected %h", obs, {OW{1'b0}});
                end
            end
            if (wash_done === 1'b1) done_at = cyc;
            advance();
        end
        n_vec++;
        if (done_at != -1) begin
            n_err++;
            $display("FAIL rst_no_done: got %0d expected -1", done_at);
        end
    endtask

`ifdef ABORT_EN
    task automatic test_abort();
        logic [OW-1:0] obs, expv;
        int            done_at;
        done_at = -1;
        do_reset();
        for (int cyc = 0; cyc <= 13; cyc++) begin
            apply(cyc == 0, 1'b0, 2'd0, 1'b0, cyc == 6, 1'b0);
            obs = dut_obs(); expv = model_obs();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL abort_model cyc %0d: got %h expected %h", cyc, obs, expv);
            end
            if (cyc == 7) begin
                n_vec++;
                if (phase !== 3'd4 || sec_left !== 9'd2) begin
                    n_err++;
                    $display("FAIL abort_entry cyc 7: got phase %0d sec %0d expected phase 4 sec 2", phase, sec_left);
                end
            end
            if (wash_done === 1'b1) done_at = cyc;
            advance();
        end
        n_vec++;
        if (done_at != 11) begin
            n_err++;
            $display("FAIL abort_done_cycle: got %0d expected 11", done_at);
        end
    endtask
`endif

    task automatic test_random();
        logic [OW-1:0] obs, expv;
        bit            finished;
        for (int run = 0; run < 8; run++) begin
            finished = 1'b0;
            do_reset();
            for (int cyc = 0; cyc < 800; cyc++) begin
                if (cyc == 0)
                    apply(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
                else
                    apply($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                          $urandom_range(0, 400) == 0);
                obs = dut_obs(); expv = model_obs();
                n_vec++;
                if (obs !== expv) begin
                    n_err++;
                    $display("FAIL random_model run %0d cyc %0d: got %h expected %h", run, cyc, obs, expv);
                end
                advance();
                if (m_phase == 0) begin
                    finished = 1'b1;
                    break;
                end
            end
            n_vec++;
            if (!finished) begin
                n_err++;
                $display("FAIL random_timeout run %0d: got busy expected idle within 800 cycles", run);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_phase = 0; m_rem = 0; m_tps = TB_BASE; m_dbl = 1'b0; m_round = 1'b0;
        coin_in = 1'b0; double_wash = 1'b0; timer_pause = 1'b0; clk_freq = 2'd0;
        abort = 1'b0; rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_double();
        test_freq();
        test_pause();
        test_coin_rst();
`ifdef ABORT_EN
        test_abort();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wash_cycle_scheduler.md
Name: wash_cycle_scheduler

Overview:
Single-timer sequencer for the wash program. It steps through the FILL, WASH, RINSE and SPIN phases and drives one enable per phase. One shared prescaler and one seconds down-counter time all phases, so no per-phase counter is needed. It sits between the coin/user inputs and the phase actuators, with wash_done as its completion output.

Parameters:
TICK_DIV_BASE, 1000000, clk cycles per second when clk_freq=00
FILL_SEC, 120, fill duration in seconds (legal 1..2^SEC_W-1)
WASH_SEC, 300, wash duration in seconds (legal 1..2^SEC_W-1)
RINSE_SEC, 120, rinse duration in seconds (legal 1..2^SEC_W-1)
SPIN_SEC, 60, spin duration in seconds (legal 1..2^SEC_W-1)
SEC_W, 9, width of the seconds counter
PRE_W, 24, width of the prescaler; must hold (TICK_DIV_BASE<<3)-1

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous reset, active-high; highest priority
coin_in  in  1  start request, honoured only in IDLE
double_wash  in  1  selects two wash/rinse rounds; sampled with coin
timer_pause  in  1  freezes timing, honoured only in SPIN
clk_freq  in  2  clock rate code; sampled with coin
phase  out  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5
fill_en  out  1  high while phase=FILL
wash_en  out  1  high while phase=WASH
rinse_en  out  1  high while phase=RINSE
spin_en  out  1  high while phase=SPIN and not paused
round2  out  1  high during the second WASH and the second RINSE
sec_left  out  SEC_W  seconds remaining in the current phase
busy  out  1  high when phase is not IDLE
wash_done  out  1  one-cycle pulse, high in DONE

Behaviour:
- Reset: phase=IDLE; all enables, round2, busy and wash_done = 0; sec_left=0; prescaler=0; latched double_wash=0; latched clk_freq=0.
- Ticks per second: TPS = TICK_DIV_BASE << clk_freq_latched.
  - Prescaler counts 0..TPS-1; tick fires in the cycle the prescaler equals TPS-1, then it wraps to 0.
- Starting: in IDLE, coin_in=1 at an edge means:
  - double_wash and clk_freq are latched;
  - next cycle phase=FILL, sec_left=FILL_SEC, prescaler=0.
- Counting:
  - each tick decrements sec_left;
  - a tick with sec_left==1 ends the phase; next cycle holds the next phase, its duration loaded into sec_left, prescaler=0;
  - every phase lasts exactly DUR*TPS cycles.
- Phase order, single wash: FILL -> WASH -> RINSE -> SPIN -> DONE -> IDLE.
- Phase order, double wash: FILL -> WASH -> RINSE -> WASH(round2) -> RINSE(round2) -> SPIN -> DONE -> IDLE.
  - round2 set on entry to the second WASH, cleared on SPIN entry.
- DONE: lasts exactly one cycle, wash_done=1, sec_left=0; IDLE follows. A coin in the DONE cycle is ignored.
- Pause:
  - timer_pause=1 in SPIN freezes the prescaler and sec_left; spin_en=0 in that cycle; release resumes the count from the frozen value;
  - timer_pause in any other phase has no effect.
- Inputs outside IDLE: coin_in, double_wash and clk_freq changes are ignored.
- Pause at a phase boundary: pause asserted in the cycle the final SPIN tick would fire suppresses that tick.
- rst mid-operation: the next edge gives reset values; the cycle in progress is abandoned with no wash_done pulse.
- Enables are decoded from registered state, so they are glitch-free and mutually exclusive.

Optional Feature:
Macro ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in FILL, WASH or RINSE gives SPIN next cycle, with sec_left=SPIN_SEC, prescaler=0 and round2=0.
  - abort in SPIN, DONE or IDLE is ignored.
  - The normal DONE pulse follows the spin.
- Not defined: no abort port; behaviour exactly as above.

Test Plan:
All scenarios use TICK_DIV_BASE=2, FILL_SEC=2, WASH_SEC=3, RINSE_SEC=2, SPIN_SEC=2. Cycle 1 is the first cycle after the coin edge.
- Single wash, clk_freq=00, double_wash=0, coin at cycle 0 -> FILL 1-4, WASH 5-10, RINSE 11-14, SPIN 15-18, wash_done=1 only at 19, IDLE at 20; sec_left 2,2,1,1 during FILL.
- Double wash, double_wash=1 at coin -> FILL 1-4, WASH 5-10, RINSE 11-14, WASH 15-20, RINSE 21-24 (round2=1 throughout 15-24), SPIN 25-28, wash_done at 29.
- clk_freq=01 -> TPS=4; FILL spans cycles 1-8 and wash_done lands at 37. Changing clk_freq mid-run has no effect.
- timer_pause=1 for 3 cycles in SPIN -> spin_en=0 and sec_left frozen in those cycles; wash_done delayed 3 cycles to 22. timer_pause during WASH -> no delay.
- coin_in pulsed during WASH -> ignored; rst=1 at cycle 7 -> cycle 8 phase=0, all outputs 0, no wash_done.
- ABORT_EN: abort=1 at cycle 6 (WASH) -> SPIN 7-10, sec_left=2 at 7, wash_done at 11.
